// File: rtl/fpga_runner.sv
// fpga_runner: loadable micro-program runner for on-board self test.
// Streams OUT values over valid/ready and checks them against a table.
module fpga_runner #(
  parameter int MemoryElementWidth = 12,
  parameter int NLocal             = 16,
  parameter int NProg              = 32,
  parameter int NExpected          = 8,
  parameter int MaxSteps           = 1000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               loadValid,
  input  logic                               loadSel,
  input  logic [7:0]                         loadAddr,
  input  logic [13+2*MemoryElementWidth:0]   loadData,
  input  logic [7:0]                         expectedCount,
  input  logic                               start,
  output logic                               outValid,
  output logic [MemoryElementWidth-1:0]      outData,
  input  logic                               outReady,
  output logic                               busy,
  output logic                               finished,
  output logic                               success,
  output logic                               error,
  output logic [15:0]                        steps
);

  localparam int W  = MemoryElementWidth;
  localparam int PW = (NProg > 1) ? $clog2(NProg) : 1;
  localparam int LW = (NLocal > 1) ? $clog2(NLocal) : 1;
  localparam int EW = (NExpected > 1) ? $clog2(NExpected) : 1;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpMov  = 4'd3;
  localparam logic [3:0] OpOut  = 4'd4;
  localparam logic [3:0] OpJeq  = 4'd5;
  localparam logic [3:0] OpJne  = 4'd6;
  localparam logic [3:0] OpJmp  = 4'd7;
  localparam logic [3:0] OpHalt = 4'd8;

  typedef struct packed {
    logic [3:0]   op;
    logic         aImm;
    logic         bImm;
    logic [7:0]   t;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } instr_t;

  typedef enum logic [1:0] {
    Idle,
    Run,
    Wait,
    Done
  } state_t;

  state_t       state;
  instr_t       progMem  [NProg];
  logic [W-1:0] expMem   [NExpected];
  logic [W-1:0] localMem [NLocal];

  logic [7:0] ip;
  logic [7:0] outCount;
  logic [7:0] expCount;
  logic       mismatch;

  instr_t       ins;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] wrData;
  logic         aBad;
  logic         bBad;
  logic         tBad;
  logic         tgtBad;
  logic         atEnd;
  logic         dog;
  logic         wrOp;
  logic         opFault;
  logic         fault;
  logic         taken;
  logic         isOut;
  logic         isHalt;
  logic         expHit;
  logic         loadEn;
  logic         wrEn;

  always_comb begin
    ins     = progMem[ip[PW-1:0]];
    valA    = ins.aImm ? ins.a : localMem[ins.a[LW-1:0]];
    valB    = ins.bImm ? ins.b : localMem[ins.b[LW-1:0]];
    aBad    = !ins.aImm && ({1'b0, ins.a[7:0]} >= 9'(NLocal));
    bBad    = !ins.bImm && ({1'b0, ins.b[7:0]} >= 9'(NLocal));
    tBad    = {1'b0, ins.t} >= 9'(NLocal);
    tgtBad  = {1'b0, ins.t} >= 9'(NProg);
    atEnd   = ip == 8'(NProg - 1);
    dog     = steps == 16'(MaxSteps);
    wrOp    = 1'b0;
    wrData  = '0;
    opFault = 1'b0;
    taken   = 1'b0;
    isOut   = 1'b0;
    isHalt  = 1'b0;
    unique case (ins.op)
      OpNop: ;
      OpAdd: begin
        wrOp    = 1'b1;
        wrData  = valA + valB;
        opFault = aBad | bBad | tBad;
      end
      OpSub: begin
        wrOp    = 1'b1;
        wrData  = valA - valB;
        opFault = aBad | bBad | tBad;
      end
      OpMov: begin
        wrOp    = 1'b1;
        wrData  = valA;
        opFault = aBad | tBad;
      end
      OpOut: begin
        isOut   = 1'b1;
        opFault = aBad;
      end
      OpJeq: begin
        opFault = aBad | bBad;
        taken   = valA == valB;
      end
      OpJne: begin
        opFault = aBad | bBad;
        taken   = valA != valB;
      end
      OpJmp:  taken  = 1'b1;
      OpHalt: isHalt = 1'b1;
      default: opFault = 1'b1;
    endcase
    // OUT checks ip overflow at its handshake, not at issue
    fault = opFault
          | (taken ? tgtBad : (!isHalt && !isOut && atEnd));
    expHit = ({1'b0, outCount} < 9'(NExpected))
          && (outData == expMem[outCount[EW-1:0]]);
    loadEn = loadValid && (state == Idle || state == Done);
  end

  assign wrEn = (state == Run) && !dog && wrOp && !opFault;

  always_ff @(posedge clock) begin
    if (loadEn && !loadSel && ({1'b0, loadAddr} < 9'(NProg)))
      progMem[loadAddr[PW-1:0]] <= instr_t'(loadData);
    if (loadEn && loadSel && ({1'b0, loadAddr} < 9'(NExpected)))
      expMem[loadAddr[EW-1:0]] <= loadData[W-1:0];
    if (wrEn)
      localMem[ins.t[LW-1:0]] <= wrData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= Idle;
      ip       <= '0;
      steps    <= '0;
      outCount <= '0;
      expCount <= '0;
      mismatch <= 1'b0;
      outValid <= 1'b0;
      outData  <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
      success  <= 1'b0;
      error    <= 1'b0;
    end else begin
      unique case (state)
        Idle, Done: begin
          if (start) begin
            state    <= Run;
            busy     <= 1'b1;
            ip       <= '0;
            steps    <= '0;
            outCount <= '0;
            mismatch <= 1'b0;
            expCount <= expectedCount;
            finished <= 1'b0;
            success  <= 1'b0;
            error    <= 1'b0;
          end
        end
        Run: begin
          if (dog) begin
            state    <= Done;
            busy     <= 1'b0;
            finished <= 1'b1;
            error    <= 1'b1;
          end else if (fault) begin
            steps    <= steps + 16'd1;
            state    <= Done;
            busy     <= 1'b0;
            finished <= 1'b1;
            error    <= 1'b1;
          end else if (isHalt) begin
            steps    <= steps + 16'd1;
            state    <= Done;
            busy     <= 1'b0;
            finished <= 1'b1;
            success  <= !mismatch && (outCount == expCount);
          end else if (isOut) begin
            outValid <= 1'b1;
            outData  <= valA;
            state    <= Wait;
          end else begin
            steps <= steps + 16'd1;
            ip    <= taken ? ins.t : ip + 8'd1;
          end
        end
        Wait: begin
          if (outReady) begin
            outValid <= 1'b0;
            steps    <= steps + 16'd1;
            outCount <= outCount + 8'd1;
            mismatch <= mismatch | !expHit;
            if (atEnd) begin
              state    <= Done;
              busy     <= 1'b0;
              finished <= 1'b1;
              error    <= 1'b1;
            end else begin
              ip    <= ip + 8'd1;
              state <= Run;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_runner.sv
// tb_fpga_runner: random programs vs. an instruction-level interpreter,
// outputs checked by a scoreboard monitor on the valid/ready channel.
module tb_fpga_runner;

  localparam int W     = 12;
  localparam int NLOC  = 16;
  localparam int NPROG = 32;
  localparam int NEXP  = 8;
  localparam int MAXS  = 1000;
  localparam int IW    = 14 + 2 * W;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          loadValid = 1'b0;
  logic          loadSel = 1'b0;
  logic [7:0]    loadAddr = '0;
  logic [IW-1:0] loadData = '0;
  logic [7:0]    expectedCount = '0;
  logic          start = 1'b0;
  logic          outReady = 1'b0;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          busy;
  logic          finished;
  logic          success;
  logic          error;
  logic [15:0]   steps;

  int checks = 0;
  int errors = 0;
  int readyMode = 0;
  int accCnt = 0;
  int stallCnt = 0;

  logic [W-1:0]  expQ [$];
  logic [IW-1:0] prog [NPROG];
  logic [W-1:0]  expTab [NEXP];
  logic [W-1:0]  lmem [NLOC];

  fpga_runner dut (
    .clock(clock),
    .reset(reset),
    .loadValid(loadValid),
    .loadSel(loadSel),
    .loadAddr(loadAddr),
    .loadData(loadData),
    .expectedCount(expectedCount),
    .start(start),
    .outValid(outValid),
    .outData(outData),
    .outReady(outReady),
    .busy(busy),
    .finished(finished),
    .success(success),
    .error(error),
    .steps(steps)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int op, input bit ai,
      input bit bi, input int t, input int a, input int b);
    logic [3:0]   o;
    logic [7:0]   tt;
    logic [W-1:0] aa;
    logic [W-1:0] bb;
    o  = op[3:0];
    tt = t[7:0];
    aa = a[W-1:0];
    bb = b[W-1:0];
    return {o, ai, bi, tt, aa, bb};
  endfunction

  task automatic wr(input bit sel, input int addr, input logic [IW-1:0] d);
    loadValid = 1'b1;
    loadSel   = sel;
    loadAddr  = addr[7:0];
    loadData  = d;
    @(negedge clock);
    loadValid = 1'b0;
  endtask

  task automatic loadProg(input int n);
    for (int i = 0; i < n; i++) wr(1'b0, i, prog[i]);
  endtask

  task automatic loadExp();
    for (int i = 0; i < NEXP; i++)
      wr(1'b1, i, {{(IW-W){1'b0}}, expTab[i]});
  endtask

  // Interpreter: runs the program from the architectural rules
  task automatic model(input int cnt, output int ms, output bit ok,
                       output bit bad);
    int ip, oc, op, t, ai, bi;
    logic [IW-1:0] w;
    logic [W-1:0] af, bf, va, vb;
    bit mis, fin, aBad, bBad, tBad, take, adv;
    ip = 0; oc = 0; ms = 0; ok = 0; bad = 0; mis = 0; fin = 0;
    while (!fin) begin
      if (ms == MAXS) begin
        bad = 1;
        break;
      end
      w  = prog[ip];
      op = int'(w[IW-1 -: 4]);
      ai = int'(w[IW-5]);
      bi = int'(w[IW-6]);
      t  = int'(w[IW-7 -: 8]);
      af = w[2*W-1 -: W];
      bf = w[W-1:0];
      aBad = (ai == 0) && (int'(af[7:0]) >= NLOC);
      bBad = (bi == 0) && (int'(bf[7:0]) >= NLOC);
      tBad = t >= NLOC;
      va = (ai != 0) ? af : (aBad ? '0 : lmem[int'(af[7:0])]);
      vb = (bi != 0) ? bf : (bBad ? '0 : lmem[int'(bf[7:0])]);
      ms++;
      take = 0;
      adv  = 1;
      case (op)
        0: ;
        1, 2, 3: begin
          if (aBad || (op != 3 && bBad) || tBad) bad = 1;
          else lmem[t] = (op == 1) ? va + vb : (op == 2) ? va - vb : va;
        end
        4: begin
          if (aBad) bad = 1;
          else begin
            expQ.push_back(va);
            if (oc >= NEXP || expTab[oc] != va) mis = 1;
            oc++;
          end
        end
        5: if (aBad || bBad) bad = 1; else take = (va == vb);
        6: if (aBad || bBad) bad = 1; else take = (va != vb);
        7: take = 1;
        8: begin
          fin = 1;
          adv = 0;
          ok  = !mis && (oc == cnt);
        end
        default: bad = 1;
      endcase
      if (bad) break;
      if (take) begin
        if (t >= NPROG) begin
          bad = 1;
          break;
        end
        ip = t;
      end else if (adv) begin
        if (ip == NPROG - 1) begin
          bad = 1;
          break;
        end
        ip++;
      end
    end
  endtask

  task automatic runTest(input int cnt, output bit mok);
    int  ms;
    bit  mbad;
    model(cnt, ms, mok, mbad);
    accCnt   = 0;
    stallCnt = 0;
    expectedCount = cnt[7:0];
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 5000 && !finished; i++) @(negedge clock);
    chk("finished", finished, 1);
    chk("success", success, mok);
    chk("error", error, mbad);
    chk("steps", steps, ms);
    chk("pending", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic loadCountdown(input int n);
    prog[0] = mk(3, 1, 0, 0, n, 0);
    prog[1] = mk(4, 0, 0, 0, 0, 0);
    prog[2] = mk(2, 0, 1, 0, 0, 1);
    prog[3] = mk(6, 0, 1, 1, 0, 0);
    prog[4] = mk(8, 0, 0, 0, 0, 0);
    loadProg(5);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        0: outReady = 1'b1;
        1: outReady = 1'($urandom_range(0, 1));
        2: begin
          if (outValid && accCnt == 1 && stallCnt < 5) begin
            outReady = 1'b0;
            stallCnt++;
          end else outReady = 1'b1;
        end
        default: outReady = 1'b0;
      endcase
    end
  end

  initial begin
    bit           held;
    logic [W-1:0] heldData;
    held = 0;
    heldData = '0;
    forever begin
      @(negedge clock);
      if (!reset) held = 0;
      else if (outValid) begin
        if (held) chk("stable", outData, heldData);
        if (outReady) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected output: got %0d expected none",
                     outData);
          end else chk("outData", outData, expQ.pop_front());
          accCnt++;
          held = 0;
        end else begin
          held = 1;
          heldData = outData;
        end
      end
    end
  end

  initial begin
    bit ok;
    int n, r1, r2, r3, cnt;
    repeat (3) @(negedge clock);
    chk("rst outValid", outValid, 0);
    chk("rst outData", outData, 0);
    chk("rst busy", busy, 0);
    chk("rst finished", finished, 0);
    chk("rst success", success, 0);
    chk("rst error", error, 0);
    chk("rst steps", steps, 0);
    reset = 1'b1;
    @(negedge clock);

    prog[0] = mk(1, 1, 1, 0, 3, 2);
    prog[1] = mk(4, 0, 0, 0, 0, 0);
    prog[2] = mk(8, 0, 0, 0, 0, 0);
    loadProg(3);
    for (int i = 0; i < NEXP; i++) expTab[i] = '0;
    expTab[0] = 12'd5;
    loadExp();
    runTest(1, ok);
    chk("add steps", steps, 3);
    chk("add success", success, 1);

    loadCountdown(4);
    for (int i = 0; i < 4; i++) expTab[i] = W'(4 - i);
    loadExp();
    runTest(4, ok);
    chk("cd success", success, 1);

    readyMode = 2;
    runTest(4, ok);
    chk("stall success", success, 1);
    chk("stall cycles", stallCnt, 5);
    readyMode = 0;

    expTab[2] = 12'd9;
    loadExp();
    runTest(4, ok);
    chk("bad tbl success", success, 0);
    chk("bad tbl error", error, 0);

    prog[0] = mk(7, 0, 0, 0, 0, 0);
    loadProg(1);
    runTest(0, ok);
    chk("dog error", error, 1);
    chk("dog steps", steps, MAXS);

    prog[0] = mk(15, 0, 0, 0, 0, 0);
    loadProg(1);
    runTest(0, ok);
    chk("illegal steps", steps, 1);

    readyMode = 1;
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 6);
      loadCountdown(n);
      for (int i = 0; i < NEXP; i++)
        expTab[i] = (i < n) ? W'(n - i) : W'($urandom);
      if ($urandom_range(0, 3) == 0) expTab[$urandom_range(0, n - 1)] ^= 1;
      loadExp();
      cnt = n + (($urandom_range(0, 3) == 0) ? 1 : 0);
      runTest(cnt, ok);
    end

    for (int k = 0; k < 5; k++) begin
      r1 = $urandom_range(0, 4095);
      r2 = ($urandom_range(0, 1) == 0) ? r1 : $urandom_range(0, 4095);
      r3 = $urandom_range(0, 4095);
      prog[0] = mk(3, 1, 0, 1, r1, 0);
      prog[1] = mk(3, 1, 0, 2, r2, 0);
      prog[2] = mk(1, 0, 0, 3, 1, 2);
      prog[3] = mk(2, 0, 0, 4, 1, 2);
      prog[4] = mk(4, 0, 0, 0, 3, 0);
      prog[5] = mk(4, 0, 0, 0, 4, 0);
      prog[6] = mk(4, 1, 0, 0, r3, 0);
      prog[7] = mk(5, 0, 0, 9, 1, 2);
      prog[8] = mk(4, 0, 0, 0, 1, 0);
      prog[9] = mk(8, 0, 0, 0, 0, 0);
      loadProg(10);
      expTab[0] = W'(r1 + r2);
      expTab[1] = W'(r1 - r2);
      expTab[2] = W'(r3);
      expTab[3] = W'(r1);
      if ($urandom_range(0, 3) == 0) expTab[$urandom_range(0, 3)] ^= 2;
      loadExp();
      runTest(4, ok);
    end

    readyMode = 3;
    loadCountdown(4);
    for (int i = 0; i < 4; i++) expTab[i] = W'(4 - i);
    loadExp();
    expectedCount = 8'd4;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 100 && !outValid; i++) @(negedge clock);
    chk("wait reached", outValid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort outValid", outValid, 0);
    chk("abort busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    chk("abort steps", steps, 0);
    chk("abort finished", finished, 0);
    chk("abort outData", outData, 0);
    readyMode = 0;
    @(negedge clock);
    runTest(4, ok);
    chk("rerun success", success, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
